// File: rtl/calc_method_select.sv
// calc_method_select: debounced next/prev/confirm buttons choose a method code, lock it on confirm, release on unlock
module calc_method_select #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_METHODS     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       unlock,
    output logic [2:0] method_sel,
    output logic       method_valid,
    output logic       locked
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [2:0] MAX_SEL = 3'(NUM_METHODS - 1);
    typedef enum logic {SELECT, LOCKED} state_t;
    logic [2:0]    w_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_deb;
    logic [2:0]    r_deb_d;
    logic [CW-1:0] r_cnt [3];
    logic [2:0]    w_evt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_sel;
    logic [2:0]    w_sel_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    assign w_raw        = {btn_confirm, btn_prev, btn_next};
    assign w_evt        = r_deb & ~r_deb_d;
    assign method_sel   = r_sel;
    assign method_valid = r_valid;
    assign locked       = (r_state == LOCKED);
    // two-flop synchronizers and the delayed debounced levels used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_d <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
        end
    end
    // per-button debouncer: toggle only after the synced level has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[i] <= ~r_deb[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end
    // selection state, method code and valid pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SELECT;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
        end
    end
    // next state: confirm beats next/prev, simultaneous next+prev cancel, unlock beats everything while locked
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_valid_nxt = 1'b0;
        if (r_state == LOCKED) begin
            if (unlock) w_state_nxt = SELECT;
        end else if (w_evt[2]) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = LOCKED;
        end else if (w_evt[0] && !w_evt[1]) begin
            w_sel_nxt = (r_sel == MAX_SEL) ? 3'd0 : r_sel + 3'd1;
        end else if (w_evt[1] && !w_evt[0]) begin
            w_sel_nxt = (r_sel == 3'd0) ? MAX_SEL : r_sel - 3'd1;
        end
    end
endmodule
